// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Shares one combinational AES-128 core (encrypt/decrypt wrapper) between
//   two requesters. Jobs are taken one at a time with round-robin grant.
//   Core inputs are registered and held for SETTLE_CYCLES edges, so the
//   core can be constrained as a multicycle path. The result is then
//   captured and returned on a tagged valid/ready response port.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   reqN_valid/ready              job handshake for requester N (N = 0, 1)
//   reqN_data/key/decrypt         block, key and mode for requester N
//   core_in/key/decrypt           registered operands to the shared core
//   core_out                      combinational core result
//   rsp_valid/ready               response handshake
//   rsp_data, rsp_id              captured result and owning requester
//   busy                          FSM not in IDLE
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | arbitrate; accept one job from the granted requester
// ST_WAIT | core operands held; count down the settle window
// ST_RESP | result captured; hold rsp_* until the consumer takes it

module aes_core_arbiter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req0_decrypt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  input  logic         req1_decrypt,
  output logic [127:0] core_in,
  output logic [127:0] core_key,
  output logic         core_decrypt,
  input  logic [127:0] core_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Count from SETTLE_CYCLES-1 down to 0; capture happens on the edge that
  // sees 0, i.e. SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       id;
  logic       grant;

  // Lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = ~rst && (state == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = ~rst && (state == ST_IDLE) &&  grant && req1_valid;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      id           <= 1'b0;
      core_in      <= '0;
      core_key     <= '0;
      core_decrypt <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            core_in      <= grant ? req1_data    : req0_data;
            core_key     <= grant ? req1_key     : req0_key;
            core_decrypt <= grant ? req1_decrypt : req0_decrypt;
            id           <= grant;
            last_grant   <= grant;
            cnt          <= CNT_LOAD;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data  <= core_out;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Returning to IDLE here means the next accept is one edge later.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
module tb_aes_core_arbiter;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;

  logic         req0_valid, req0_ready, req0_decrypt;
  logic [127:0] req0_data, req0_key;
  logic         req1_valid, req1_ready, req1_decrypt;
  logic [127:0] req1_data, req1_key;
  logic [127:0] core_in, core_key, core_out;
  logic         core_decrypt;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [127:0] rsp_data;

  logic         s_req0_valid, s_req0_ready, s_req1_ready;
  logic [127:0] s_core_in, s_core_key, s_core_out, s_rsp_data;
  logic         s_core_decrypt, s_rsp_valid, s_rsp_ready, s_rsp_id, s_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in for the AES core: knows the FIPS-197 vector pair, scrambles
  // anything else so wrong operands give a wrong result.
  function automatic logic [127:0] core_model(input logic [127:0] din,
                                              input logic [127:0] key,
                                              input logic dec);
    if (!dec && din == PT && key == KY) return CT;
    if ( dec && din == CT && key == KY) return PT;
    return {din[63:0], din[127:64]} ^ key ^ {128{dec}};
  endfunction

  always_comb core_out   = core_model(core_in, core_key, core_decrypt);
  always_comb s_core_out = core_model(s_core_in, s_core_key, s_core_decrypt);

  aes_core_arbiter #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_key(req0_key), .req0_decrypt(req0_decrypt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_key(req1_key), .req1_decrypt(req1_decrypt),
    .core_in(core_in), .core_key(core_key), .core_decrypt(core_decrypt),
    .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  aes_core_arbiter #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_data(PT),
    .req0_key(KY), .req0_decrypt(1'b0),
    .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_data('0),
    .req1_key('0), .req1_decrypt(1'b0),
    .core_in(s_core_in), .core_key(s_core_key), .core_decrypt(s_core_decrypt),
    .core_out(s_core_out),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rsp_id(s_rsp_id), .busy(s_busy)
  );

  // Wait (bounded) for a ready, let the accept edge pass, drop that valid.
  // Returns at the falling edge after the accept edge.
  task automatic wait_accept(output logic got, output logic which);
    got = 1'b0;
    which = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        which = req1_ready;
        got = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (which) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Rising edges from the accept edge until rsp_valid is seen; -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = PT; req0_key = KY; req0_decrypt = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_key = '0; req1_decrypt = 1'b0;
    rsp_ready = 1'b0;
    s_req0_valid = 1'b0; s_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (core_in !== 128'h0) begin errors++; $display("FAIL reset_core_in: got %h expected 0", core_in); end
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL release_ready0: got %b expected 1", req0_ready); end
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_encrypt();
    logic got, which;
    int lat;
    req0_valid = 1'b1; req0_data = PT; req0_key = KY; req0_decrypt = 1'b0;
    wait_accept(got, which);
    checks++;
    if (got !== 1'b1 || which !== 1'b0) begin errors++; $display("FAIL single_accept: got %b/%b expected 1/0", got, which); end
    checks++;
    if (core_in !== PT || core_key !== KY || core_decrypt !== 1'b0) begin
      errors++; $display("FAIL single_core_regs: got %h expected %h", core_in, PT);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", lat); end
    checks++;
    if (rsp_data !== CT) begin errors++; $display("FAIL single_data: got %h expected %h", rsp_data, CT); end
    checks++;
    if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", rsp_id); end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== CT || busy !== 1'b0) begin
      errors++; $display("FAIL single_after: got valid=%b data=%h busy=%b expected 0 %h 0", rsp_valid, rsp_data, busy, CT);
    end
    checks++;
    if (core_in !== PT) begin errors++; $display("FAIL idle_hold_core_in: got %h expected %h", core_in, PT); end
  endtask

  task automatic test_contention();
    logic got, which, exp;
    int lat;
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = PT; req0_key = KY; req0_decrypt = 1'b0;
    req1_valid = 1'b1; req1_data = CT; req1_key = KY; req1_decrypt = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      // jobs 0,1 from reset; jobs 2..5 re-presented by both; job 6 drains req0
      if (k >= 2 && k <= 5) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
      end
      exp = k[0];
      wait_accept(got, which);
      wait_rsp(lat);
      checks++;
      if (got !== 1'b1 || rsp_id !== exp) begin
        errors++; $display("FAIL contention_id[%0d]: got %b expected %b", k, rsp_id, exp);
      end
      checks++;
      if (rsp_data !== (exp ? PT : CT) || lat != 4) begin
        errors++; $display("FAIL contention_data[%0d]: got %h lat %0d expected %h lat 4", k, rsp_data, lat, exp ? PT : CT);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic got, which;
    int lat;
    logic ok;
    req0_valid = 1'b1; req0_data = PT; req0_key = KY; req0_decrypt = 1'b0;
    wait_accept(got, which);
    wait_rsp(lat);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== CT || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL backpressure_hold: got valid=%b data=%h id=%b rdy=%b%b busy=%b expected 1 %h 0 00 1",
                         rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, busy, CT);
    end
    consume();
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: got busy=%b valid=%b expected 0 0", busy, rsp_valid);
    end
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL backpressure_next_grant: got %b%b expected 10", req1_ready, req0_ready);
    end
    wait_accept(got, which);
    wait_rsp(lat);
    consume();
    wait_accept(got, which);
    wait_rsp(lat);
    checks++;
    if (rsp_id !== 1'b0 || rsp_data !== CT) begin
      errors++; $display("FAIL backpressure_drain: got id=%b data=%h expected 0 %h", rsp_id, rsp_data, CT);
    end
    consume();
  endtask

  task automatic test_reset_mid_wait();
    logic got, which;
    int lat;
    logic seen;
    req0_valid = 1'b1; req0_data = PT; req0_key = KY; req0_decrypt = 1'b0;
    wait_accept(got, which);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got busy=%b valid=%b expected 0 0", busy, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp: got activity=%b expected 0", seen); end
    req1_valid = 1'b1; req1_data = CT; req1_key = KY; req1_decrypt = 1'b1;
    wait_accept(got, which);
    wait_rsp(lat);
    checks++;
    if (got !== 1'b1 || which !== 1'b1 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL midreset_req1_id: got %b expected 1", rsp_id);
    end
    checks++;
    if (rsp_data !== PT || lat != 4) begin
      errors++; $display("FAIL midreset_req1_data: got %h lat %0d expected %h lat 4", rsp_data, lat, PT);
    end
    consume();
  endtask

  task automatic test_settle1();
    int lat;
    logic got;
    s_req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_req0_ready) begin
        got = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_req0_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (!got) break;
      @(posedge clk);
      @(negedge clk);
      if (s_rsp_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL settle1_latency: got %0d expected 1", lat); end
    checks++;
    if (s_rsp_data !== CT || s_rsp_id !== 1'b0) begin
      errors++; $display("FAIL settle1_data: got %h id %b expected %h id 0", s_rsp_data, s_rsp_id, CT);
    end
    s_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_rsp_ready = 1'b0;
    checks++;
    if (s_busy !== 1'b0 || s_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL settle1_release: got busy=%b valid=%b expected 0 0", s_busy, s_rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_encrypt();
    test_contention();
    test_backpressure();
    test_reset_mid_wait();
    test_settle1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
